rand_index_sampler: RTL

- Consumer end of the LFSR random-word stream. Pulls raw words through a valid/ready handshake.
- Turns the raw words into K distinct, uniformly distributed indices in [0, limit). It does this by masking and rejection sampling.
- Sits between the LFSR instances and the selection/crossover logic of the EC datapath. Typical uses: tournament selection, picking crossover points.

---
 rtl/rand_index_sampler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rand_index_sampler.sv
// rand_index_sampler: pulls raw LFSR words and turns them into K distinct
// indices in [0, limit). Low bits of each word form a candidate. A candidate
// is rejected if it is out of range or equals an index already emitted in the
// current request.
module rand_index_sampler #(
   parameter int S_WIDTH   = 8,
   parameter int IND_WIDTH = 6,
   parameter int K_MAX     = 4,
   parameter int K_WIDTH   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [IND_WIDTH:0]   limit_i,
   input  logic [K_WIDTH-1:0]   k_i,
   input  logic                 rnd_valid_i,
   input  logic [S_WIDTH-1:0]   rnd_data_i,
   output logic                 rnd_ready_o,
   output logic                 idx_valid_o,
   output logic [IND_WIDTH-1:0] idx_o,
   output logic                 idx_last_o,
   input  logic                 idx_ready_i,
   output logic                 busy_o,
   output logic                 err_o,
   output logic [7:0]           rej_cnt_o
);

   typedef enum logic [1:0] {IDLE, DRAW, EMIT} state_t;

   localparam logic [IND_WIDTH:0] LIMIT_MAX = (IND_WIDTH+1)'(1) << IND_WIDTH;

   state_t               state_q, state_d;
   logic [IND_WIDTH:0]   limit_q, limit_d;
   logic [K_WIDTH-1:0]   k_q, k_d;
   logic [K_WIDTH-1:0]   cnt_q, cnt_d;
   logic [IND_WIDTH-1:0] hist_q [K_MAX];
   logic [IND_WIDTH-1:0] hist_d [K_MAX];
   logic [IND_WIDTH-1:0] idx_q, idx_d;
   logic                 idx_last_q, idx_last_d;
   logic                 err_q, err_d;
   logic [7:0]           rej_cnt_q, rej_cnt_d;

   logic [IND_WIDTH-1:0] cand;
   logic                 in_range;
   logic                 dup;
   logic                 accept;
   logic                 req_legal;
   logic                 unused_hi_bits;

   // Saturating increment for the rejection counter.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign unused_hi_bits = ^rnd_data_i[S_WIDTH-1:IND_WIDTH];

   // Candidate qualification: range check plus compare against every stored index.
   always_comb begin
      cand     = rnd_data_i[IND_WIDTH-1:0];
      in_range = ({1'b0, cand} < limit_q);
      dup      = 1'b0;
      for (int j = 0; j < K_MAX; j++) begin
         if ((K_WIDTH'(j) < cnt_q) && (hist_q[j] == cand)) dup = 1'b1;
      end
      accept    = (state_q == DRAW) && rnd_valid_i && in_range && !dup;
      req_legal = (limit_i != '0) && (limit_i <= LIMIT_MAX) && (k_i != '0) &&
                  (int'(k_i) <= K_MAX) && (int'(k_i) <= int'(limit_i));
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i && req_legal) state_d = DRAW;
         DRAW:    if (accept) state_d = EMIT;
         EMIT:    if (idx_ready_i) state_d = idx_last_q ? IDLE : DRAW;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and status outputs depend on registered state only.
   always_comb begin
      rnd_ready_o = (state_q == DRAW);
      idx_valid_o = (state_q == EMIT);
      busy_o      = (state_q != IDLE);
   end

   // Datapath updates: request latch, history write, counters.
   always_comb begin
      limit_d    = limit_q;
      k_d        = k_q;
      cnt_d      = cnt_q;
      hist_d     = hist_q;
      idx_d      = idx_q;
      idx_last_d = idx_last_q;
      err_d      = 1'b0;
      rej_cnt_d  = rej_cnt_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               limit_d   = limit_i;
               k_d       = k_i;
               cnt_d     = '0;
               rej_cnt_d = '0;
               err_d     = !req_legal;
            end
         end
         DRAW: begin
            if (accept) begin
               idx_d      = cand;
               idx_last_d = (cnt_q == k_q - K_WIDTH'(1));
               for (int j = 0; j < K_MAX; j++) begin
                  if (K_WIDTH'(j) == cnt_q) hist_d[j] = cand;
               end
            end else if (rnd_valid_i) begin
               rej_cnt_d = sat_inc(rej_cnt_q);
            end
         end
         EMIT: begin
            if (idx_ready_i) cnt_d = cnt_q + K_WIDTH'(1);
         end
         default: ;
      endcase
   end

   // State and datapath registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         limit_q    <= '0;
         k_q        <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         idx_last_q <= 1'b0;
         err_q      <= 1'b0;
         rej_cnt_q  <= '0;
         for (int j = 0; j < K_MAX; j++) hist_q[j] <= '0;
      end else begin
         state_q    <= state_d;
         limit_q    <= limit_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         idx_last_q <= idx_last_d;
         err_q      <= err_d;
         rej_cnt_q  <= rej_cnt_d;
         hist_q     <= hist_d;
      end
   end

   assign idx_o      = idx_q;
   assign idx_last_o = idx_last_q;
   assign err_o      = err_q;
   assign rej_cnt_o  = rej_cnt_q;

endmodule
